switch_debouncer: RTL and testbench

//  Conditions the raw board slide switches before they reach the 3-8 decoder stage.

---
 rtl/switch_debouncer_if.sv | 20 ++
 rtl/switch_debouncer.sv | 106 ++++++++++
 tb/tb_switch_debouncer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw switch levels in, clean levels and edge strobes out.
interface switch_debouncer_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] db_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             busy;

    modport master (
        output raw_in,
        input  db_out, rise_pulse, fall_pulse, busy
    );

    modport slave (
        input  raw_in,
        output db_out, rise_pulse, fall_pulse, busy
    );
endinterface

// File: rtl/switch_debouncer.sv
// Synchronises and debounces raw slide switches into clean levels with per-bit
// rise/fall strobes; one debounce lane per input bit.
module switch_debouncer_lane #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic db,
    output logic rise,
    output logic fall,
    output logic pend_next
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Counter value is the lane state: zero is STABLE, nonzero is QUALIFY.
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             accept;

    assign mismatch  = (sync != db);
    assign accept    = mismatch && (cnt == CNT_LAST);
    assign pend_next = mismatch && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            db   <= RESET_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!mismatch) begin
                cnt <= '0;
            end else if (accept) begin
                cnt  <= '0;
                db   <= sync;
                rise <= sync;
                fall <= ~sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module switch_debouncer #(
    parameter int               WIDTH           = 6,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_debouncer_if.slave   bus
);
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] lane_db;
    logic [WIDTH-1:0] lane_rise;
    logic [WIDTH-1:0] lane_fall;
    logic [WIDTH-1:0] lane_pend;
    logic             busy;

    // Plain two-flop chain: raw_in is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= bus.raw_in;
            sync2 <= sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            switch_debouncer_lane #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_BIT       (RESET_VAL[i])
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .sync      (sync2[i]),
                .db        (lane_db[i]),
                .rise      (lane_rise[i]),
                .fall      (lane_fall[i]),
                .pend_next (lane_pend[i])
            );
        end
    endgenerate

    // busy tracks the counters' next value so it is a flop aligned with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= 1'b0;
        else        busy <= |lane_pend;
    end

    assign bus.db_out     = lane_db;
    assign bus.rise_pulse = lane_rise;
    assign bus.fall_pulse = lane_fall;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: table vectors plus corner-case sequences, scoreboard checked.
module tb_switch_debouncer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_debouncer_if #(.WIDTH(6)) bus ();
    switch_debouncer_if #(.WIDTH(6)) bus1 ();
    assign bus1.raw_in = bus.raw_in;

    switch_debouncer #(.WIDTH(6), .DEBOUNCE_CYCLES(4), .RESET_VAL(6'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    switch_debouncer #(.WIDTH(6), .DEBOUNCE_CYCLES(1), .RESET_VAL(6'h00)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [5:0] raw;
        logic [5:0] db;
        logic [5:0] rise;
        logic [5:0] fall;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [5:0] db;
        logic [5:0] rise;
        logic [5:0] fall;
        logic       busy;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one raw value, expect a state after the next edge.
    task automatic step(input logic [5:0] raw, input logic [5:0] db, input logic [5:0] r,
                        input logic [5:0] f, input logic b, input string nm);
        exp_t e;
        bus.raw_in = raw;
        sb.push_back('{db, r, f, b, nm});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, {13'd0, bus.db_out, bus.rise_pulse, bus.fall_pulse, bus.busy},
              {13'd0, e.db, e.rise, e.fall, e.busy});
    endtask

    task automatic add(input logic [5:0] raw, input logic [5:0] db, input logic [5:0] r,
                       input logic [5:0] f, input logic b);
        tbl.push_back('{raw, db, r, f, b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] bounce_raw;
        logic [13:0] bounce_busy;
        bounce_raw  = 14'b11111100110011;
        bounce_busy = 14'b01110011001100;

        // Clean step 0->25, glitch on bit3, 25->02, simultaneous 02->20.
        add(6'h25, 6'h00, 6'h00, 6'h00, 0); add(6'h25, 6'h00, 6'h00, 6'h00, 0);
        add(6'h25, 6'h00, 6'h00, 6'h00, 1); add(6'h25, 6'h00, 6'h00, 6'h00, 1);
        add(6'h25, 6'h00, 6'h00, 6'h00, 1); add(6'h25, 6'h25, 6'h25, 6'h00, 0);
        add(6'h25, 6'h25, 6'h00, 6'h00, 0);
        add(6'h2D, 6'h25, 6'h00, 6'h00, 0); add(6'h2D, 6'h25, 6'h00, 6'h00, 0);
        add(6'h2D, 6'h25, 6'h00, 6'h00, 1); add(6'h25, 6'h25, 6'h00, 6'h00, 1);
        add(6'h25, 6'h25, 6'h00, 6'h00, 1); add(6'h25, 6'h25, 6'h00, 6'h00, 0);
        add(6'h25, 6'h25, 6'h00, 6'h00, 0);
        add(6'h02, 6'h25, 6'h00, 6'h00, 0); add(6'h02, 6'h25, 6'h00, 6'h00, 0);
        add(6'h02, 6'h25, 6'h00, 6'h00, 1); add(6'h02, 6'h25, 6'h00, 6'h00, 1);
        add(6'h02, 6'h25, 6'h00, 6'h00, 1); add(6'h02, 6'h02, 6'h02, 6'h25, 0);
        add(6'h02, 6'h02, 6'h00, 6'h00, 0);
        add(6'h20, 6'h02, 6'h00, 6'h00, 0); add(6'h20, 6'h02, 6'h00, 6'h00, 0);
        add(6'h20, 6'h02, 6'h00, 6'h00, 1); add(6'h20, 6'h02, 6'h00, 6'h00, 1);
        add(6'h20, 6'h02, 6'h00, 6'h00, 1); add(6'h20, 6'h20, 6'h20, 6'h02, 0);
        add(6'h20, 6'h20, 6'h00, 6'h00, 0);

        // Reset held with all switches high.
        bus.raw_in = 6'h3F;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            step(6'h3F, 6'h00, 6'h00, 6'h00, 0, "reset_hold");
            check("reset_hold_d1", {26'd0, bus1.db_out}, 32'h0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(6'h3F, (k >= 6) ? 6'h3F : 6'h00, (k == 6) ? 6'h3F : 6'h00, 6'h00,
                 (k >= 3 && k <= 5), "release");
            check("release_d1", {26'd0, bus1.db_out}, (k >= 3) ? 32'h3F : 32'h0);
        end
        for (int k = 1; k <= 7; k++)
            step(6'h00, (k >= 6) ? 6'h00 : 6'h3F, 6'h00, (k == 6) ? 6'h3F : 6'h00,
                 (k >= 3 && k <= 5), "fall_all");

        foreach (tbl[j])
            step(tbl[j].raw, tbl[j].db, tbl[j].rise, tbl[j].fall, tbl[j].busy,
                 $sformatf("table[%0d]", j));

        // Bounce on bit0 from db=20; settles 6 edges after the last toggle.
        for (int k = 1; k <= 14; k++)
            step({5'b10000, bounce_raw[k-1]}, (k == 14) ? 6'h21 : 6'h20,
                 (k == 14) ? 6'h01 : 6'h00, 6'h00, bounce_busy[k-1],
                 $sformatf("bounce[%0d]", k));

        // Reset in the middle of qualifying bit2.
        for (int k = 1; k <= 4; k++)
            step(6'h25, 6'h21, 6'h00, 6'h00, (k >= 3), "pre_reset");
        rst_n = 1'b0;
        #1;
        check("mid_reset", {13'd0, bus.db_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 32'h0);
        step(6'h25, 6'h00, 6'h00, 6'h00, 0, "mid_reset_hold");
        step(6'h25, 6'h00, 6'h00, 6'h00, 0, "mid_reset_hold");
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++)
            step(6'h25, (k >= 6) ? 6'h25 : 6'h00, (k == 6) ? 6'h25 : 6'h00, 6'h00,
                 (k >= 3 && k <= 5), "restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
